acq_capture: RTL

- Triggered acquisition engine: the receive-side counterpart of the signal generator.
- Accepts an ADC sample stream and writes it into a circular sample buffer.
- Holds a programmable pre-trigger history, waits for a masked trigger, captures a programmable post-trigger length, then stops.
- Software reads the buffer through a simple read port; the block sits between the ADC stream and the system-bus register/buffer decoder.

---
 rtl/acq_capture.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/acq_capture.sv
// rtl/acq_capture.sv - triggered acquisition engine with circular sample buffer and read port
// Optional ACQ_DECIMATION_EN adds cfg_dec: only every (cfg_dec+1)-th valid sample is stored.
module acq_capture #(
  parameter int DW = 14,
  parameter int AW = 14,
  parameter int CW = 32,
  parameter int TN = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] sti_tdata,
  input  logic          sti_tvalid,
  output logic          sti_tready,
  input  logic [TN-1:0] trg_ext,
  input  logic          trg_swi,
  output logic          trg_out,
  output logic          irq_trg,
  output logic          irq_stp,
  input  logic          ctl_rst,
  input  logic          ctl_acq,
  input  logic          ctl_stp,
  input  logic [TN-1:0] cfg_trg,
  input  logic [CW-1:0] cfg_pre,
  input  logic [CW-1:0] cfg_pst,
`ifdef ACQ_DECIMATION_EN
  input  logic [15:0]   cfg_dec,
`endif
  output logic          sts_run,
  output logic          sts_trg,
  output logic [AW-1:0] sts_wpt,
  output logic [AW-1:0] sts_tpt,
  input  logic          buf_ren,
  input  logic [AW-1:0] buf_addr,
  output logic [DW-1:0] buf_rdata,
  output logic          buf_ack
);

  typedef enum logic [1:0] {IDLE, PRE, ARM, POST} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt_pre, cnt_pst;
  logic [AW-1:0] wpt, tpt;
  logic          run, post_done, trig, trg_hit, stop_evt, acc, dec_hit, start;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_q;
  logic          ren_q;

  assign sti_tready = 1'b1;
  assign run        = (state != IDLE);
  assign start      = (state == IDLE) && ctl_acq;
  // POST stops before the sample that would exceed the post-trigger length
  assign post_done  = (state == POST) && (cnt_pst == cfg_pst);
  assign trig       = (|(trg_ext & cfg_trg)) | trg_swi;
  assign acc        = sti_tvalid && run && dec_hit && !post_done;
  assign sts_run    = run;
  assign sts_wpt    = wpt;
  assign sts_tpt    = tpt;

`ifdef ACQ_DECIMATION_EN
  logic [15:0] dec_cnt;
  assign dec_hit = (dec_cnt == cfg_dec);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                    dec_cnt <= '0;
    else if (ctl_rst || start)    dec_cnt <= '0;
    else if (sti_tvalid && run)   dec_cnt <= dec_hit ? 16'd0 : dec_cnt + 16'd1;
  end
`else
  assign dec_hit = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    trg_hit   = 1'b0;
    case (state)
      IDLE: if (ctl_acq) state_nxt = PRE;
      PRE:  if (cnt_pre == cfg_pre) state_nxt = ARM;
      ARM:  if (trig) begin
              trg_hit   = 1'b1;
              state_nxt = POST;
            end
      POST: if (post_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // abort overrides both a trigger and normal completion
    if (ctl_stp && run) begin
      state_nxt = IDLE;
      trg_hit   = 1'b0;
    end
  end

  assign stop_evt = run && (state_nxt == IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn || ctl_rst) begin
      state   <= IDLE;
      cnt_pre <= '0;
      cnt_pst <= '0;
      wpt     <= '0;
      tpt     <= '0;
      sts_trg <= 1'b0;
      trg_out <= 1'b0;
      irq_trg <= 1'b0;
      irq_stp <= 1'b0;
    end else begin
      state   <= state_nxt;
      trg_out <= trg_hit;
      irq_trg <= trg_hit;
      irq_stp <= stop_evt;
      if (start) begin
        wpt     <= '0;
        cnt_pre <= '0;
        cnt_pst <= '0;
        sts_trg <= 1'b0;
      end else begin
        if (acc) wpt <= wpt + 1'b1;
        if (acc && state == PRE)  cnt_pre <= cnt_pre + 1'b1;
        if (acc && state == POST) cnt_pst <= cnt_pst + 1'b1;
        if (trg_hit) begin
          tpt     <= wpt;
          sts_trg <= 1'b1;
          cnt_pst <= '0;
        end
      end
    end
  end

  // read-first RAM: a read of the address being written returns the old word
  always_ff @(posedge clk) begin
    if (acc) mem[wpt] <= sti_tdata;
    rd_q <= mem[buf_addr];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn || ctl_rst) begin
      ren_q     <= 1'b0;
      buf_ack   <= 1'b0;
      buf_rdata <= '0;
    end else begin
      ren_q     <= buf_ren;
      buf_ack   <= ren_q;
      buf_rdata <= ren_q ? rd_q : '0;
    end
  end

endmodule
